pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data field and a control field from an upstream stage to a downstream stage using a valid/ready handshake. It also supports synchronous flush (bubble insertion) and a saturating stall-cycle counter. An optional 2-entry skid buffer registers `inReady`, which breaks the combinational ready path between stages.

---
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage register uses the slave view; its environment uses the master view.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 25
);
   logic              inValid;
   logic              inReady;
   logic [DATA_W-1:0] inData;
   logic [CTRL_W-1:0] inCtrl;
   logic              outValid;
   logic              outReady;
   logic [DATA_W-1:0] outData;
   logic [CTRL_W-1:0] outCtrl;

   modport master (
      output inValid, inData, inCtrl, outReady,
      input  inReady, outValid, outData, outCtrl
   );

   modport slave (
      input  inValid, inData, inCtrl, outReady,
      output inReady, outValid, outData, outCtrl
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_SKID_EN to add a skid entry so that inReady comes straight from a flop.
module pipe_stage_reg #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 25,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             resetN,
   pipe_stage_reg_if.slave  bus,
   input  logic             flush,
   output logic [CNT_W-1:0] stallCount
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              main_valid_r;
   logic [DATA_W-1:0] main_data_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic [CNT_W-1:0]  stall_cnt_r;

   logic              main_valid_s;
   logic [DATA_W-1:0] main_data_s;
   logic [CTRL_W-1:0] main_ctrl_s;
   logic              drain_s;
   logic              in_ready_s;
   logic              in_xfer_s;

   assign drain_s      = !main_valid_r || bus.outReady;
   assign in_xfer_s    = bus.inValid && in_ready_s;
   assign bus.inReady  = in_ready_s;
   assign bus.outValid = main_valid_r;
   assign bus.outData  = main_data_r;
   assign bus.outCtrl  = main_ctrl_r;
   assign stallCount   = stall_cnt_r;

`ifdef PIPE_SKID_EN
   logic              skid_valid_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic              in_ready_r;
   logic              skid_valid_s;
   logic [DATA_W-1:0] skid_data_s;
   logic [CTRL_W-1:0] skid_ctrl_s;

   assign in_ready_s = in_ready_r;

   // Next-state selection for main and skid entries; skid always drains first.
   always_comb begin
      main_valid_s = main_valid_r;
      main_data_s  = main_data_r;
      main_ctrl_s  = main_ctrl_r;
      skid_valid_s = skid_valid_r;
      skid_data_s  = skid_data_r;
      skid_ctrl_s  = skid_ctrl_r;
      if (flush) begin
         main_valid_s = 1'b0;
         main_ctrl_s  = {CTRL_W{1'b0}};
         skid_valid_s = 1'b0;
      end else if (drain_s) begin
         if (skid_valid_r) begin
            main_valid_s = 1'b1;
            main_data_s  = skid_data_r;
            main_ctrl_s  = skid_ctrl_r;
            skid_valid_s = 1'b0;
         end else if (in_xfer_s) begin
            main_valid_s = 1'b1;
            main_data_s  = bus.inData;
            main_ctrl_s  = bus.inCtrl;
         end else begin
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
         end
      end else begin
         if (in_xfer_s) begin
            skid_valid_s = 1'b1;
            skid_data_s  = bus.inData;
            skid_ctrl_s  = bus.inCtrl;
         end else begin
            skid_valid_s = skid_valid_r;
         end
      end
   end

   // Stage state registers; inReady is registered from the next skid occupancy.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {DATA_W{1'b0}};
         main_ctrl_r  <= {CTRL_W{1'b0}};
         skid_valid_r <= 1'b0;
         skid_data_r  <= {DATA_W{1'b0}};
         skid_ctrl_r  <= {CTRL_W{1'b0}};
         in_ready_r   <= 1'b0;
      end else begin
         main_valid_r <= main_valid_s;
         main_data_r  <= main_data_s;
         main_ctrl_r  <= main_ctrl_s;
         skid_valid_r <= skid_valid_s;
         skid_data_r  <= skid_data_s;
         skid_ctrl_r  <= skid_ctrl_s;
         in_ready_r   <= !skid_valid_s;
      end
   end
`else
   assign in_ready_s = resetN && drain_s;

   // Next-state selection for the single main entry.
   always_comb begin
      main_valid_s = main_valid_r;
      main_data_s  = main_data_r;
      main_ctrl_s  = main_ctrl_r;
      if (flush) begin
         main_valid_s = 1'b0;
         main_ctrl_s  = {CTRL_W{1'b0}};
      end else if (drain_s) begin
         if (in_xfer_s) begin
            main_valid_s = 1'b1;
            main_data_s  = bus.inData;
            main_ctrl_s  = bus.inCtrl;
         end else begin
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
         end
      end else begin
         main_valid_s = main_valid_r;
      end
   end

   // Stage state registers.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {DATA_W{1'b0}};
         main_ctrl_r  <= {CTRL_W{1'b0}};
      end else begin
         main_valid_r <= main_valid_s;
         main_data_r  <= main_data_s;
         main_ctrl_r  <= main_ctrl_s;
      end
   end
`endif

   // Saturating count of stalled cycles; flush does not touch it.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (main_valid_r && !bus.outReady && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic, checked against a queue model.
// A second instance with a 4-bit stall counter checks saturation under the same stimulus.
module tb_pipe_stage_reg;
   localparam int DW = 160;
   localparam int CW = 25;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, in_valid, out_ready, flush;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic [15:0]   stall_count;
   logic [3:0]    stall_count_sat;

   pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) ifa ();
   pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) ifb ();

   assign ifa.inValid  = in_valid;
   assign ifa.inData   = in_data;
   assign ifa.inCtrl   = in_ctrl;
   assign ifa.outReady = out_ready;
   assign ifb.inValid  = in_valid;
   assign ifb.inData   = in_data;
   assign ifb.inCtrl   = in_ctrl;
   assign ifb.outReady = out_ready;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
      .clk(clk), .resetN(reset_n), .bus(ifa.slave), .flush(flush), .stallCount(stall_count)
   );
   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_sat (
      .clk(clk), .resetN(reset_n), .bus(ifb.slave), .flush(flush), .stallCount(stall_count_sat)
   );

   // Reference model: beats held by the stage, oldest first.
   beat_t         q[$];
   logic [DW-1:0] hold = '0;
   int            cnt = 0;
   logic          rdy_ok = 1'b0;
   int            total = 0;
   int            bad = 0;

   // Holding source for the random phase.
   logic          pend_v = 1'b0;
   logic [DW-1:0] pend_d;
   logic [CW-1:0] pend_c;
   int            seq = 1;

   function automatic logic [DW-1:0] rnd160();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [CW-1:0] exp_c;
      if (q.size() > 0) exp_c = q[0].c;
      else exp_c = '0;
      chk("out_valid",   192'(ifa.outValid),    192'(q.size() > 0));
      chk("out_ctrl",    192'(ifa.outCtrl),     192'(exp_c));
      chk("out_data",    192'(ifa.outData),     192'(hold));
      chk("stall_count", 192'(stall_count),     192'((cnt > 65535) ? 65535 : cnt));
      chk("stall_sat",   192'(stall_count_sat), 192'((cnt > 15) ? 15 : cnt));
      chk("sat_ctrl",    192'(ifb.outCtrl),     192'(exp_c));
   endtask

   // One clock: drive, check inReady, advance the model over the edge, check outputs.
   task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic ordy, input logic fl, input logic rn, output logic acc);
      logic  exp_rdy;
      beat_t b;
      in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy; flush = fl; reset_n = rn;
      #2;
`ifdef PIPE_SKID_EN
      exp_rdy = rdy_ok && (q.size() < 2);
`else
      exp_rdy = rn && (ordy || (q.size() == 0));
`endif
      chk("in_ready", 192'(ifa.inReady), 192'(exp_rdy));
      acc = iv && exp_rdy;
      @(posedge clk);
      if (!rn) begin
         q.delete();
         hold   = '0;
         cnt    = 0;
         rdy_ok = 1'b0;
      end else begin
         if ((q.size() > 0) && !ordy) cnt++;
         if (fl) begin
            q.delete();
         end else begin
            if ((q.size() > 0) && ordy) void'(q.pop_front());
            if (acc) begin
               b.d = id; b.c = ic;
               q.push_back(b);
            end
         end
         rdy_ok = 1'b1;
      end
      if (q.size() > 0) hold = q[0].d;
      #1;
      check_outputs();
   endtask

   task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                       input logic ordy, input logic fl, input logic rn);
      logic acc;
      cycle(iv, id, ic, ordy, fl, rn, acc);
   endtask

   task automatic src_cycle(input logic want, input logic ordy, input logic fl, input logic rn);
      logic acc;
      if (!pend_v && want) begin
         pend_v = 1'b1;
         pend_d = rnd160();
         pend_c = CW'(seq);
         seq++;
      end
      cycle(pend_v, pend_d, pend_c, ordy, fl, rn, acc);
      if (acc) pend_v = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      in_data = '0; in_ctrl = '0;
      @(posedge clk); #1;
      repeat (2) step(1'b1, rnd160(), 25'd9, 1'b1, 1'b0, 1'b0);
      chk("rst_stall", 192'(stall_count), 192'd0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

      // Streaming 1..8 back-to-back
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, rnd160(), CW'(i), 1'b1, 1'b0, 1'b1);
         chk("stream_ctrl", 192'(ifa.outCtrl), 192'(i));
      end
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("stream_stall", 192'(stall_count), 192'd0);

      // Stall hold with 0xA5 in the stage
      step(1'b1, 160'hA5, 25'h5A, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 160'hB6, 25'h6B, 1'b0, 1'b0, 1'b1);
      chk("stall5_cnt",  192'(stall_count), 192'd5);
      chk("stall5_data", 192'(ifa.outData), 192'h0A5);
      repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

      // Flush with beats held and an incoming beat
      step(1'b1, 160'hC1, 25'd1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 160'hC2, 25'd2, 1'b0, 1'b0, 1'b1);
      step(1'b1, 160'hC3, 25'd3, 1'b0, 1'b1, 1'b1);
      chk("flush_valid", 192'(ifa.outValid), 192'd0);
      chk("flush_ctrl",  192'(ifa.outCtrl),  192'd0);
      step(1'b1, 160'hC4, 25'd4, 1'b1, 1'b0, 1'b1);
      chk("post_flush", 192'(ifa.outCtrl), 192'd4);
      step(1'b1, 160'hC5, 25'd5, 1'b1, 1'b1, 1'b1);
      step(1'b1, 160'hC6, 25'd6, 1'b1, 1'b0, 1'b1);
      chk("flush_discard", 192'(ifa.outCtrl), 192'd6);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

      // Simultaneous transfer with a one-cycle outReady dip
      for (int i = 0; i < 12; i++) src_cycle(1'b1, (i != 5), 1'b0, 1'b1);
      repeat (3) src_cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // Saturation of the 4-bit counter
      step(1'b1, rnd160(), 25'd55, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("sat15", 192'(stall_count_sat), 192'd15);

      // Reset mid-stall, then a fresh beat
      step(1'b1, rnd160(), 25'd66, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_valid", 192'(ifa.outValid), 192'd0);
      chk("rst_mid_data",  192'(ifa.outData),  192'd0);
      chk("rst_mid_cnt",   192'(stall_count),  192'd0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 160'h77, 25'd77, 1'b1, 1'b0, 1'b1);
      chk("rst_first_beat", 192'(ifa.outCtrl), 192'd77);

      // Random traffic
      for (int i = 0; i < 400; i++)
         src_cycle(($urandom() % 4) != 0, ($urandom() % 4) != 0,
                   ($urandom() % 20) == 0, ($urandom() % 80) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
